// File: rtl/hazard_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_sched                                                             |
// | Load-use stall detection and EX/MEM forwarding select for a 5-stage core. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

// Opcode header values; an including build may supply its own shared definitions.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef RTYPE
`define RTYPE 6'b000000
`endif
`ifndef LOAD
`define LOAD 6'b100011
`endif
`ifndef STORE
`define STORE 6'b101011
`endif
`ifndef BEQ
`define BEQ 6'b000100
`endif
`ifndef BNE
`define BNE 6'b000101
`endif
`ifndef ADDI
`define ADDI 6'b001000
`endif
`ifndef ADDIU
`define ADDIU 6'b001001
`endif
`ifndef SLTI
`define SLTI 6'b001010
`endif
`ifndef SLTIU
`define SLTIU 6'b001011
`endif
`ifndef ANDI
`define ANDI 6'b001100
`endif
`ifndef ORI
`define ORI 6'b001101
`endif

module hazard_sched #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [`OPCODE_WIDTH-1:0] id_opcode,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     flush,
  output logic                     stall,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic [1:0] c_fwd_rf  = 2'b00;
  localparam logic [1:0] c_fwd_ex  = 2'b01;
  localparam logic [1:0] c_fwd_mem = 2'b10;

  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic [REG_AW-1:0] r_ex_dest, r_mem_dest, r_wb_dest;
  logic              r_ex_load, r_mem_load, r_wb_load;
  logic [1:0]        r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [REG_AW-1:0] w_dest;
  logic              w_rs_used, w_rt_used, w_is_load;
  logic              w_rs_live, w_rt_live, w_hit, w_stall, w_advance;

  always_comb begin
    w_dest    = '0;
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    w_is_load = 1'b0;
    case (id_opcode)
      `RTYPE: begin
        w_dest    = id_rd;
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      `LOAD: begin
        w_dest    = id_rt;
        w_rs_used = 1'b1;
        w_is_load = 1'b1;
      end
      `ADDI, `ADDIU, `SLTI, `SLTIU, `ANDI, `ORI: begin
        w_dest    = id_rt;
        w_rs_used = 1'b1;
      end
      `STORE, `BEQ, `BNE: begin
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      default: ;
    endcase
  end

  // A zero dest never matches because live sources are nonzero.
  assign w_rs_live = id_valid && w_rs_used && (id_rs != '0);
  assign w_rt_live = id_valid && w_rt_used && (id_rt != '0);
  assign w_hit     = r_ex_valid && r_ex_load &&
                     ((w_rs_live && (id_rs == r_ex_dest)) ||
                      (w_rt_live && (id_rt == r_ex_dest)));
  assign w_stall   = !rst && id_valid && !flush && w_hit;
  assign w_advance = id_valid && !flush && !w_stall;

  function automatic logic [1:0] fwd_sel(input logic live, input logic [REG_AW-1:0] src);
    if (!live)                                 return c_fwd_rf;
    else if (r_ex_valid && r_ex_dest == src)   return c_fwd_ex;
    else if (r_mem_valid && r_mem_dest == src) return c_fwd_mem;
    else                                       return c_fwd_rf;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_dest   <= '0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_dest  <= '0;
      r_mem_load  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_load   <= 1'b0;
      r_fwd_a     <= c_fwd_rf;
      r_fwd_b     <= c_fwd_rf;
      r_stall_cnt <= '0;
    end else begin
      r_ex_valid  <= w_advance;
      r_ex_dest   <= w_advance ? w_dest : '0;
      r_ex_load   <= w_advance && w_is_load;
      r_mem_valid <= r_ex_valid;
      r_mem_dest  <= r_ex_dest;
      r_mem_load  <= r_ex_load;
      r_wb_valid  <= r_mem_valid;
      r_wb_dest   <= r_mem_dest;
      r_wb_load   <= r_mem_load;
      r_fwd_a     <= fwd_sel(w_advance && w_rs_live, id_rs);
      r_fwd_b     <= fwd_sel(w_advance && w_rt_live, id_rt);
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // WB is tracked for pipeline completeness only; the register file is write-before-read.
  logic w_unused_wb;
  assign w_unused_wb = &{1'b0, r_wb_valid, r_wb_dest, r_wb_load, r_mem_load};

  assign stall     = w_stall;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_sched                                                          |
// | Directed scoreboard bench for hazard_sched.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_sched;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [5:0]        id_opcode = '0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb_q[$];

  hazard_sched #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one ID slot, check stall, then check the forwarding selects it produced.
  task automatic step(input string tag, input logic v, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic fl, input logic exp_stall,
                      input logic [1:0] exp_a, input logic [1:0] exp_b);
    logic [3:0] e;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    sb_q.push_back({exp_a, exp_b});
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(e[3:2]));
      chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(e[1:0]));
    end
  endtask

  task automatic bubble();
    step("bubble", 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fwd_a", 32'(fwd_a), 32'd0);
    chk("rst.fwd_b", 32'(fwd_b), 32'd0);
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // Back-to-back ALU forward from EX/MEM
    step("b2b.add1", 1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
    step("b2b.add2", 1'b1, OP_R, 5'd3, 5'd4, 5'd6, 1'b0, 1'b0, 2'b01, 2'b00);
    bubble(); bubble();

    // Distance-2 forward, then newest-wins
    step("d2.addi", 1'b1, OP_ADDI, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    bubble();
    step("d2.sub", 1'b1, OP_R, 5'd1, 5'd5, 5'd8, 1'b0, 1'b0, 2'b00, 2'b10);
    step("nw.addi", 1'b1, OP_ADDI, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("nw.add", 1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 2'b00, 2'b00);
    step("nw.sub", 1'b1, OP_R, 5'd1, 5'd5, 5'd9, 1'b0, 1'b0, 2'b00, 2'b01);
    bubble(); bubble();

    // Load-use: one stall cycle, then MEM/WB forward
    step("lu.lw", 1'b1, OP_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("lu.stall", 1'b1, OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b1, 2'b00, 2'b00);
    chk("lu.cnt1", 32'(stall_cnt), 32'd1);
    step("lu.go", 1'b1, OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b0, 2'b10, 2'b00);
    chk("lu.cnt_hold", 32'(stall_cnt), 32'd1);
    bubble(); bubble();

    // Invalid slot ignores its fields
    step("inv.lw", 1'b1, OP_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("inv.slot", 1'b0, OP_R, 5'd7, 5'd7, 5'd9, 1'b0, 1'b0, 2'b00, 2'b00);
    step("inv.add", 1'b1, OP_R, 5'd7, 5'd0, 5'd9, 1'b0, 1'b0, 2'b10, 2'b00);
    bubble(); bubble();

    // Immediate operand is not a hazard; $0 never forwards
    step("imm.lw", 1'b1, OP_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("imm.addi", 1'b1, OP_ADDI, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("z.add_rd0", 1'b1, OP_R, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("z.add_rs0", 1'b1, OP_R, 5'd0, 5'd7, 5'd10, 1'b0, 1'b0, 2'b00, 2'b10);
    bubble(); bubble();

    // Store uses rt: load-use on rt
    step("sw.lw", 1'b1, OP_LW, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("sw.stall", 1'b1, OP_SW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00);
    step("sw.go", 1'b1, OP_SW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 2'b00, 2'b10);
    chk("sw.cnt2", 32'(stall_cnt), 32'd2);
    bubble(); bubble();

    // Flush overrides stall
    step("fl.lw", 1'b1, OP_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    step("fl.flush", 1'b1, OP_R, 5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("fl.cnt", 32'(stall_cnt), 32'd2);
    step("fl.next", 1'b1, OP_R, 5'd7, 5'd0, 5'd11, 1'b0, 1'b0, 2'b10, 2'b00);

    // Saturation
    for (int i = 0; i < 15; i++) begin
      step("sat.lw", 1'b1, OP_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("sat.stall", 1'b1, OP_R, 5'd7, 5'd0, 5'd11, 1'b0, 1'b1, 2'b00, 2'b00);
      step("sat.go", 1'b1, OP_R, 5'd7, 5'd0, 5'd11, 1'b0, 1'b0, 2'b10, 2'b00);
      chk("sat.cnt", 32'(stall_cnt), (3 + i > 15) ? 32'd15 : 32'(3 + i));
    end

    // Asynchronous reset in the middle of a stall
    step("rs.add", 1'b1, OP_R, 5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00);
    step("rs.lw", 1'b1, OP_LW, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00);
    id_valid = 1'b1; id_opcode = OP_R; id_rs = 5'd7; id_rt = 5'd0; id_rd = 5'd11; flush = 1'b0;
    #1;
    chk("rs.pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs.stall", 32'(stall), 32'd0);
    chk("rs.fwd_a", 32'(fwd_a), 32'd0);
    chk("rs.fwd_b", 32'(fwd_b), 32'd0);
    chk("rs.cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("rs.after", 1'b1, OP_R, 5'd7, 5'd0, 5'd11, 1'b0, 1'b0, 2'b00, 2'b00);
    chk("rs.cnt_after", 32'(stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL take opcode width from the shared header constant OPCODE_WIDTH and decode only the header opcode macros (RTYPE, LOAD, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, STORE, BEQ, BNE).
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID-stage slot holds a real instruction.
- id_opcode  in  OPCODE_WIDTH  ID-stage opcode.
- id_rs, id_rt, id_rd  in  REG_AW each  ID-stage register specifiers.
- flush  in  1  branch/jump redirect; kills the ID-stage instruction.
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- fwd_a  out  2  registered ALU operand-A source for the EX-stage instruction.
- fwd_b  out  2  registered ALU operand-B register source for the EX-stage instruction, applied before the immediate/register operand mux.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-005 SHALL decode the destination as rd for RTYPE, rt for LOAD/ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI, and none otherwise; a destination of 0 SHALL count as none.
REQ-006 SHALL treat rs as used for RTYPE, the I-type ALU group, LOAD, STORE, BEQ and BNE, and rt as used only for RTYPE, STORE, BEQ and BNE.
REQ-007 SHALL keep three registered stage records, EX, MEM and WB, each holding {valid, dest, is_load}, advancing ID->EX->MEM->WB every cycle.
REQ-008 SHALL assert stall when id_valid=1, flush=0, the EX record is valid with is_load=1, and its dest equals a used, nonzero source of the ID instruction.
REQ-009 SHALL, in a stall cycle, load a bubble (valid=0) into the EX record while MEM and WB still advance; the stall lasts exactly one cycle per load-use pair.
REQ-010 SHALL, when flush=1, load a bubble into the EX record and drive stall=0 in that cycle; flush has priority over stall.
REQ-011 SHALL compute next-cycle fwd_a/fwd_b per used source s with this priority: EX record dest==s -> 2'b01 (from EX/MEM); else MEM record dest==s -> 2'b10 (from MEM/WB); else 2'b00 (register file).
REQ-012 SHALL register 2'b00 for an unused source, a source of 0, a bubble, or a stall/flush cycle; 2'b11 SHALL never be produced.
REQ-013 SHALL not forward from the WB record; the register file is write-before-read.
REQ-014 SHALL increment stall_cnt on every cycle with stall=1, saturate at all ones, and never wrap.
REQ-015 SHALL ignore id_rs/id_rt/id_rd/id_opcode when id_valid=0 (stall=0, bubble enters EX).

Reset
REQ-016 SHALL, on rst=1 at any time, asynchronously clear all stage records to invalid, fwd_a=fwd_b=2'b00, and stall_cnt=0; stall SHALL read 0 while rst=1.
REQ-017 SHALL resume normal operation on the first rising clk edge after rst deasserts, with no pending stall carried across reset.

Verification
REQ-018 Back-to-back ALU use: ADD rd=3, then ADD rs=3 rt=4 -> no stall; second instruction in EX sees fwd_a=01, fwd_b=00.
REQ-019 Distance-2 forward: ADDI rt=5, NOP, SUB rt=5 -> fwd_b=10 in SUB's EX cycle; an intervening ADD rd=5 instead yields fwd_b=01 (newest wins).
REQ-020 Load-use: LOAD rt=7, then ADD rs=7 -> stall=1 for exactly 1 cycle, stall_cnt 0->1, then ADD in EX with fwd_a=10.
REQ-021 Immediate is not a hazard: LOAD rt=7, then ADDI rs=2 rt=7 -> stall=0, fwd_b=00; register $0: ADD rd=0, then ADD rs=0 -> fwd_a=00.
REQ-022 Flush vs stall: a load-use pair with flush=1 in the hazard cycle -> stall=0, bubble in EX, stall_cnt unchanged.
REQ-023 Saturation and reset: preload stall_cnt to all ones via repeated load-use pairs -> stays all ones; assert rst mid-stall -> stall=0, fwd_a=fwd_b=00, stall_cnt=0 without a clock edge.
